// File: rtl/mac_pkg.sv
// mac_pkg: operation codes, parameter sanity check and the saturating
// adder shared by the mac_bank accumulator engine.
package mac_pkg;

  // Operation encoding as seen on in_op.
  typedef enum logic [1:0] {
    OP_LOAD = 2'b00,
    OP_MAC  = 2'b01,
    OP_MSC  = 2'b10,
    OP_CLR  = 2'b11
  } mac_op_e;

  // Widest accumulator the shared adder can handle.
  localparam int MAX_ACC_W = 128;

  // The accumulator must at least hold a full product; bits beyond that are guard bits.
  localparam int GUARD_MIN_FACTOR = 2;

  // True when the width pair is legal for the engine.
  function automatic bit acc_w_ok(input int data_w, input int acc_w);
    return (data_w >= 1) && (acc_w >= GUARD_MIN_FACTOR * data_w) && (acc_w < MAX_ACC_W);
  endfunction

  // Adds two sign-extended operands and fits the sum into acc_w bits.
  // Returns {ovf, value}; only value[acc_w-1:0] is meaningful to the caller.
  // ovf is set when the exact sum is not representable in acc_w bits; the
  // value is then clamped (sat_en) or the low acc_w bits are kept (wrap).
  function automatic logic [MAX_ACC_W:0] sat_add(
    input logic signed [MAX_ACC_W-1:0] a,
    input logic signed [MAX_ACC_W-1:0] b,
    input int                          acc_w,
    input bit                          sat_en
  );
    logic signed [MAX_ACC_W:0] sum;
    logic signed [MAX_ACC_W:0] top;
    logic [MAX_ACC_W-1:0]      lim;
    logic [MAX_ACC_W-1:0]      val;
    logic                      ovf;
    sum = {a[MAX_ACC_W-1], a} + {b[MAX_ACC_W-1], b};
    // Every bit from the acc_w-1 sign position upward must agree for the sum to fit.
    top = sum >>> (acc_w - 1);
    ovf = !((top == '0) || (&top));
    // lim holds the most negative value; its complement is the most positive one.
    lim = {MAX_ACC_W{1'b1}} << (acc_w - 1);
    val = sum[MAX_ACC_W-1:0];
    if (ovf && sat_en) begin
      val = sum[MAX_ACC_W] ? lim : ~lim;
    end
    return {ovf, val};
  endfunction

endpackage

// File: rtl/mac_acc_bank.sv
// mac_acc_bank: per-channel accumulators and sticky overflow flags. Performs
// the read-modify-write of acc[ch] in a single cycle so that back-to-back
// operations on one channel need no forwarding.
module mac_acc_bank
  import mac_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int ACC_W    = 40,
  parameter int CHANNELS = 4,
  parameter int SAT_EN   = 1,
  parameter int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      i_en,
  input  mac_op_e                   i_op,
  input  logic [CH_W-1:0]           i_ch,
  input  logic signed [2*DATA_W-1:0] i_prod,
  output logic                      o_hit,
  output logic signed [ACC_W-1:0]   o_acc,
  output logic                      o_ovf
);

  logic signed [ACC_W-1:0]     r_acc [CHANNELS];
  logic                        r_ovf [CHANNELS];

  logic                        w_in_range;
  logic                        w_wr;
  logic signed [ACC_W-1:0]     w_acc_cur;
  logic signed [MAX_ACC_W-1:0] w_opa;
  logic signed [MAX_ACC_W-1:0] w_opb;
  logic [MAX_ACC_W:0]          w_sat_full;
  logic                        w_ovf_next;
  logic                        w_unused_hi;

  // A bank that fills the whole channel code space needs no range check.
  if ((1 << CH_W) == CHANNELS) begin : g_full_range
    assign w_in_range = 1'b1;
  end else begin : g_partial_range
    assign w_in_range = ({1'b0, i_ch} < (CH_W + 1)'(CHANNELS));
  end

  // Out-of-range channels turn the operation into a bubble.
  assign w_wr      = i_en && w_in_range;
  assign w_acc_cur = r_acc[i_ch];

  // Select adder operands: LOAD = 0 + p, MAC = acc + p, MSC = acc - p, CLR = 0 + 0.
  always_comb begin
    w_opa = '0;
    w_opb = '0;
    case (i_op)
      OP_LOAD: w_opb = MAX_ACC_W'(i_prod);
      OP_MAC: begin
        w_opa = MAX_ACC_W'(w_acc_cur);
        w_opb = MAX_ACC_W'(i_prod);
      end
      OP_MSC: begin
        w_opa = MAX_ACC_W'(w_acc_cur);
        w_opb = -(MAX_ACC_W'(i_prod));
      end
      default: begin
        w_opa = '0;
        w_opb = '0;
      end
    endcase
  end

  assign w_sat_full  = sat_add(w_opa, w_opb, ACC_W, SAT_EN != 0);
  assign w_unused_hi = ^w_sat_full[MAX_ACC_W-1:ACC_W];

  // LOAD and CLR restart the channel, so they also clear its sticky flag.
  assign w_ovf_next = ((i_op == OP_LOAD) || (i_op == OP_CLR)) ? 1'b0
                    : (r_ovf[i_ch] | w_sat_full[MAX_ACC_W]);

  assign o_hit = w_wr;
  assign o_acc = w_sat_full[ACC_W-1:0];
  assign o_ovf = w_ovf_next;

  // Commit the updated accumulator and flag of the addressed channel.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < CHANNELS; i++) begin
        r_acc[i] <= '0;
        r_ovf[i] <= 1'b0;
      end
    end else if (w_wr) begin
      r_acc[i_ch] <= o_acc;
      r_ovf[i_ch] <= w_ovf_next;
    end
  end

endmodule

// File: rtl/mac_bank.sv
// mac_bank: pipelined multi-channel multiply-accumulate engine. Operand stage,
// product stage, then accumulate + output register, all frozen together while
// the consumer holds off a pending result.
module mac_bank
  import mac_pkg::*;
#(
  parameter  int DATA_W   = 16,
  parameter  int ACC_W    = 40,
  parameter  int CHANNELS = 4,
  parameter  int SAT_EN   = 1,
  localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [1:0]               in_op,
  input  logic [CH_W-1:0]          in_ch,
  input  logic signed [DATA_W-1:0] in_a,
  input  logic signed [DATA_W-1:0] in_b,
  input  logic                     in_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CH_W-1:0]          out_ch,
  output logic signed [ACC_W-1:0]  out_acc,
  output logic                     out_ovf
);

  localparam int PROD_W = 2 * DATA_W;

  if (!acc_w_ok(DATA_W, ACC_W) || (CHANNELS < 1)) begin : g_bad_params
    $error("mac_bank: need DATA_W >= 1, 2*DATA_W <= ACC_W < %0d and CHANNELS >= 1", MAX_ACC_W);
  end

  // Operand stage
  logic                     r_s1_valid;
  mac_op_e                  r_s1_op;
  logic [CH_W-1:0]          r_s1_ch;
  logic signed [DATA_W-1:0] r_s1_a;
  logic signed [DATA_W-1:0] r_s1_b;
  logic                     r_s1_last;
  // Product stage
  logic                     r_s2_valid;
  mac_op_e                  r_s2_op;
  logic [CH_W-1:0]          r_s2_ch;
  logic signed [PROD_W-1:0] r_s2_prod;
  logic                     r_s2_last;
  // Output register
  logic                     r_out_valid;
  logic [CH_W-1:0]          r_out_ch;
  logic signed [ACC_W-1:0]  r_out_acc;
  logic                     r_out_ovf;

  logic                     w_stall;
  logic                     w_bank_en;
  logic                     w_bank_hit;
  logic signed [ACC_W-1:0]  w_bank_acc;
  logic                     w_bank_ovf;
  logic                     w_emit;

  // A held result that the consumer refuses freezes the whole pipe.
  assign w_stall   = r_out_valid && !out_ready;
  assign in_ready  = !w_stall;
  assign w_bank_en = r_s2_valid && !w_stall;
  assign w_emit    = w_bank_hit && r_s2_last;

  // Capture the offered operation when the pipe is moving.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s1_valid <= 1'b0;
      r_s1_op    <= OP_LOAD;
      r_s1_ch    <= '0;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
      r_s1_last  <= 1'b0;
    end else if (!w_stall) begin
      r_s1_valid <= in_valid;
      r_s1_op    <= mac_op_e'(in_op);
      r_s1_ch    <= in_ch;
      r_s1_a     <= in_a;
      r_s1_b     <= in_b;
      r_s1_last  <= in_last;
    end
  end

  // Register the full-width signed product alongside its control fields.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s2_valid <= 1'b0;
      r_s2_op    <= OP_LOAD;
      r_s2_ch    <= '0;
      r_s2_prod  <= '0;
      r_s2_last  <= 1'b0;
    end else if (!w_stall) begin
      r_s2_valid <= r_s1_valid;
      r_s2_op    <= r_s1_op;
      r_s2_ch    <= r_s1_ch;
      r_s2_prod  <= PROD_W'(r_s1_a) * PROD_W'(r_s1_b);
      r_s2_last  <= r_s1_last;
    end
  end

  mac_acc_bank #(
    .DATA_W   (DATA_W),
    .ACC_W    (ACC_W),
    .CHANNELS (CHANNELS),
    .SAT_EN   (SAT_EN),
    .CH_W     (CH_W)
  ) u_bank (
    .clk     (clk),
    .reset_n (reset_n),
    .i_en    (w_bank_en),
    .i_op    (r_s2_op),
    .i_ch    (r_s2_ch),
    .i_prod  (r_s2_prod),
    .o_hit   (w_bank_hit),
    .o_acc   (w_bank_acc),
    .o_ovf   (w_bank_ovf)
  );

  // Load a new result or retire the consumed one; a simultaneous consume and
  // arrival simply overwrites, so there is no bubble between results.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_out_valid <= 1'b0;
      r_out_ch    <= '0;
      r_out_acc   <= '0;
      r_out_ovf   <= 1'b0;
    end else if (!w_stall) begin
      r_out_valid <= w_emit;
      if (w_emit) begin
        r_out_ch  <= r_s2_ch;
        r_out_acc <= w_bank_acc;
        r_out_ovf <= w_bank_ovf;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_ch    = r_out_ch;
  assign out_acc   = r_out_acc;
  assign out_ovf   = r_out_ovf;

endmodule
